seg7_scan_driver: RTL and testbench

- Downstream of the six-digit display mux in the D-Clock datapath.
- Takes the six selected BCD digits (q0..q5 of the mux) plus per-digit decimal points and time-multiplexes them onto one common 7-segment bus with six digit enables.
- Contains the refresh prescaler, scan counter, frame-synchronous shadow latch and anti-ghosting blank window.
- Feeds the board pins directly.

---
 rtl/disp_pkg.sv | 30 +++
 rtl/bcd_to_seg7.sv | 17 +
 rtl/seg7_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants for the multiplexed 7-segment display path.
//   NUM_DIGITS - digits on the common segment bus
//   BCD_DASH   - digit code that lights the dash (segment g only)
//   BCD_BLANK  - digit code used to blank a digit
//   SEG_CODES  - 16-entry table of logical segment codes {g,f,e,d,c,b,a},
//                indexed by the 4-bit digit code (a = bit 0)
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_DASH  = 7'h40;

    localparam bcd_t BCD_DASH  = 4'hA;
    localparam bcd_t BCD_BLANK = 4'hF;

    // Entry 15 first, entry 0 last. Codes 0..9 are the standard digits,
    // 4'hA is a dash, 4'hB..4'hF are dark.
    localparam logic [15:0][6:0] SEG_CODES = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_DASH,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational digit-code to logical segment decoder. No pin polarity is
// applied here; a 1 on an output bit means "segment lit".
//   bcd_i  in  4  digit code (0-9 digits, A dash, B-F blank)
//   seg_o  out 7  logical segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_CODES[bcd_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexes six digit codes onto one common 7-segment bus with six
// digit enables. Contains the refresh prescaler, the scan index, a shadow
// latch that is reloaded once per frame (no tearing), and a blank window at
// the start of every slot so the previous digit cannot ghost onto the next.
//
// Optional feature (macro DISP_BLINK_EN): per-digit blinking driven by a
// frame counter; without the macro blink_mask is ignored.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   d0..d5            digit codes, d0 is the leftmost digit
//   dp_mask           bit i lights the decimal point of digit i
//   blink_mask        bit i blinks digit i (DISP_BLINK_EN only)
//   enable            0 darkens the display without stopping the scan
//   seg, dp           segment and decimal point pins
//   dig               digit enable pins, bit i = digit i
//   frame_tick        one-cycle pulse when the shadow registers load
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import disp_pkg::*;
#(
    parameter int DIV            = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter int BLINK_FRAMES   = 83
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [5:0] dp_mask,
    input  logic [5:0] blink_mask,
    input  logic       enable,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig,
    output logic       frame_tick
);

    localparam int              CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [2:0]                       idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]       shadow_q;
    logic [NUM_DIGITS-1:0]            dp_sh_q;
    logic [6:0]                       seg_q, seg_d;
    logic                             dp_q, dp_d;
    logic [NUM_DIGITS-1:0]            dig_q, dig_d;
    logic                             slot_tick;
    logic                             blink_off;
    logic [6:0]                       seg_dec;

    assign slot_tick  = (cnt_q == CNT_LAST);
    // The shadow load happens on the last cycle of the last slot, so the new
    // frame starts at digit 0 with fresh data.
    assign frame_tick = slot_tick && (idx_q == IDX_LAST);

    // Prescaler and scan index advance.
    always_comb begin
        cnt_d = slot_tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Frame-synchronous shadow latch; starts blank so the first frame is dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= {NUM_DIGITS{BCD_BLANK}};
            dp_sh_q  <= '0;
        end else if (frame_tick) begin
            shadow_q <= {d5, d4, d3, d2, d1, d0};
            dp_sh_q  <= dp_mask;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int              FR_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] blink_sh_q;

    // Blink phase flips every BLINK_FRAMES frames; it changes on the same edge
    // the shadows load, so a digit blanks for whole frames only.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick) begin
            if (frame_cnt_q == FR_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blink_sh_q    <= '0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (frame_tick) begin
                blink_sh_q <= blink_mask;
            end
        end
    end

    assign blink_off = blink_phase_q & blink_sh_q[idx_q];
`else
    logic unused_blink;

    assign blink_off    = 1'b0;
    assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
`endif

    bcd_to_seg7 u_decode (
        .bcd_i (shadow_q[idx_q]),
        .seg_o (seg_dec)
    );

    // Output stage in logical polarity. Segments and digit enable are taken
    // from the same idx/cnt state, so they always change on the same edge.
    always_comb begin
        seg_d = blink_off ? SEG_BLANK : seg_dec;
        dp_d  = dp_sh_q[idx_q] & ~blink_off;
        dig_d = '0;
        if (enable && (cnt_q >= CNT_BLANK)) begin
            dig_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b0;
            dig_q <= '0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            dig_q <= dig_d;
        end
    end

    assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp  = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
    assign dig = DIG_ACTIVE_LOW ? ~dig_q : dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with DIV=8, BLANK_CYCLES=2,
// BLINK_FRAMES=2 and active-low pins. A reference model derives the expected
// pins from the number of clock edges since reset using plain arithmetic.
// Honours DISP_BLINK_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BFR   = 2;
    localparam int FRAME = 6 * DIV;

`ifdef DISP_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam logic [6:0] SEGTAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d [6];
    logic [5:0] dp_mask, blink_mask;
    logic       enable;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig;
    logic       frame_tick;

    int pass_count  = 0;
    int check_count = 0;

    // Reference model state
    int         n, loads, m_c, m_i;
    logic [3:0] m_sh [6];
    logic [5:0] m_dp, m_bm;
    logic [6:0] e_seg, m_lit;
    logic       e_dp, e_ft, m_ldp;
    logic [5:0] e_dig;

    seg7_scan_driver #(
        .DIV            (DIV),
        .BLANK_CYCLES   (BLANK),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1),
        .BLINK_FRAMES   (BFR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d0         (d[0]),
        .d1         (d[1]),
        .d2         (d[2]),
        .d3         (d[3]),
        .d4         (d[4]),
        .d5         (d[5]),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .enable     (enable),
        .seg        (seg),
        .dp         (dp),
        .dig        (dig),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Model: after n edges the slot counter is n mod DIV and the digit is
    // (n div DIV) mod 6; the pins show the state one edge earlier. Frames end
    // at n mod 48 == 47, which is where the inputs are captured.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            loads = 0;
            for (int i = 0; i < 6; i++) m_sh[i] = 4'hF;
            m_dp  = '0;
            m_bm  = '0;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_dig = 6'h3F;
            e_ft  = 1'b0;
        end else begin
            m_c   = n % DIV;
            m_i   = (n / DIV) % 6;
            m_lit = SEGTAB[m_sh[m_i]];
            m_ldp = m_dp[m_i];
            if (BLINK_ON && (((loads / BFR) % 2) == 1) && m_bm[m_i]) begin
                m_lit = 7'h00;
                m_ldp = 1'b0;
            end
            e_seg = ~m_lit;
            e_dp  = ~m_ldp;
            e_dig = (enable && m_c >= BLANK) ? ~(6'b000001 << m_i) : 6'h3F;
            if (n % FRAME == FRAME - 1) begin
                for (int i = 0; i < 6; i++) m_sh[i] = d[i];
                m_dp  = dp_mask;
                m_bm  = blink_mask;
                loads = loads + 1;
            end
            n    = n + 1;
            e_ft = (n % FRAME == FRAME - 1);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        dp_mask = '0;
        blink_mask = '0;
        for (int i = 0; i < 6; i++) d[i] = 4'd0;
        repeat (3) @(negedge clk);
        check_count++;
        if (seg !== 7'h7F) $display("[TB] FAIL reset_seg: got %h expected 7f", seg);
        else pass_count++;
        check_count++;
        if (dp !== 1'b1) $display("[TB] FAIL reset_dp: got %b expected 1", dp);
        else pass_count++;
        check_count++;
        if (dig !== 6'h3F) $display("[TB] FAIL reset_dig: got %b expected 111111", dig);
        else pass_count++;
        check_count++;
        if (frame_tick !== 1'b0) $display("[TB] FAIL reset_frame_tick: got %b expected 0", frame_tick);
        else pass_count++;
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        for (int i = 0; i < 6; i++) d[i] = 4'(i + 1);
        dp_mask = 6'b000100;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check_count++;
            if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft})
                $display("[TB] FAIL first_frame k=%0d: got seg=%h dp=%b dig=%b ft=%b expected seg=%h dp=%b dig=%b ft=%b",
                         k, seg, dp, dig, frame_tick, e_seg, e_dp, e_dig, e_ft);
            else pass_count++;
            check_count++;
            if (seg !== 7'h7F) $display("[TB] FAIL first_frame_blank k=%0d: got seg=%h expected 7f", k, seg);
            else pass_count++;
            if (k == FRAME - 1) begin
                check_count++;
                if (frame_tick !== 1'b1) $display("[TB] FAIL first_frame_tick: got %b expected 1", frame_tick);
                else pass_count++;
            end
        end
    endtask

    task automatic test_digits_dp();
        int active = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check_count++;
            if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft})
                $display("[TB] FAIL digits_dp k=%0d: got seg=%h dp=%b dig=%b ft=%b expected seg=%h dp=%b dig=%b ft=%b",
                         k, seg, dp, dig, frame_tick, e_seg, e_dp, e_dig, e_ft);
            else pass_count++;
            if (dig !== 6'h3F) active++;
            if (dig === 6'b111110) begin
                check_count++;
                if (seg !== 7'h79) $display("[TB] FAIL digit0_seg: got %h expected 79", seg);
                else pass_count++;
            end
            if (dig === 6'b111011) begin
                check_count++;
                if ({seg, dp} !== {7'h30, 1'b0}) $display("[TB] FAIL digit2_seg_dp: got seg=%h dp=%b expected seg=30 dp=0", seg, dp);
                else pass_count++;
            end else if (dig !== 6'h3F) begin
                check_count++;
                if (dp !== 1'b1) $display("[TB] FAIL other_dp: got %b expected 1 (dig=%b)", dp, dig);
                else pass_count++;
            end
        end
        check_count++;
        if (active != 6 * (DIV - BLANK)) $display("[TB] FAIL blank_window_count: got %0d expected %0d", active, 6 * (DIV - BLANK));
        else pass_count++;
    endtask

    task automatic test_frame_sync();
        for (int k = 1; k <= 2 * FRAME; k++) begin
            @(negedge clk);
            check_count++;
            if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft})
                $display("[TB] FAIL frame_sync k=%0d: got seg=%h dp=%b dig=%b ft=%b expected seg=%h dp=%b dig=%b ft=%b",
                         k, seg, dp, dig, frame_tick, e_seg, e_dp, e_dig, e_ft);
            else pass_count++;
            if (dig === 6'b110111) begin
                check_count++;
                if (seg !== ((k <= FRAME) ? 7'h19 : 7'h10))
                    $display("[TB] FAIL digit3_tearing k=%0d: got %h expected %h", k, seg, (k <= FRAME) ? 7'h19 : 7'h10);
                else pass_count++;
            end
            if (k == 10) d[3] = 4'd9;
        end
    endtask

    task automatic test_codes();
        d[1] = 4'hA;
        d[4] = 4'hC;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            @(negedge clk);
            check_count++;
            if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft})
                $display("[TB] FAIL codes k=%0d: got seg=%h dp=%b dig=%b ft=%b expected seg=%h dp=%b dig=%b ft=%b",
                         k, seg, dp, dig, frame_tick, e_seg, e_dp, e_dig, e_ft);
            else pass_count++;
            if (k > FRAME && dig === 6'b111101) begin
                check_count++;
                if (seg !== 7'h3F) $display("[TB] FAIL dash_code: got %h expected 3f", seg);
                else pass_count++;
            end
            if (k > FRAME && dig === 6'b101111) begin
                check_count++;
                if (seg !== 7'h7F) $display("[TB] FAIL blank_code: got %h expected 7f", seg);
                else pass_count++;
            end
        end
    endtask

    task automatic test_enable_off();
        int ticks = 0;
        enable = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            check_count++;
            if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft})
                $display("[TB] FAIL enable_off k=%0d: got seg=%h dp=%b dig=%b ft=%b expected seg=%h dp=%b dig=%b ft=%b",
                         k, seg, dp, dig, frame_tick, e_seg, e_dp, e_dig, e_ft);
            else pass_count++;
            check_count++;
            if (dig !== 6'h3F) $display("[TB] FAIL enable_off_dark k=%0d: got %b expected 111111", k, dig);
            else pass_count++;
            if (frame_tick === 1'b1) ticks++;
        end
        check_count++;
        if (ticks != 2) $display("[TB] FAIL enable_off_ticks: got %0d expected 2", ticks);
        else pass_count++;
        enable = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            check_count++;
            if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft})
                $display("[TB] FAIL enable_resume k=%0d: got seg=%h dp=%b dig=%b ft=%b expected seg=%h dp=%b dig=%b ft=%b",
                         k, seg, dp, dig, frame_tick, e_seg, e_dp, e_dig, e_ft);
            else pass_count++;
        end
    endtask

    task automatic test_random();
        for (int k = 1; k <= 6 * FRAME; k++) begin
            @(negedge clk);
            check_count++;
            if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft})
                $display("[TB] FAIL random k=%0d: got seg=%h dp=%b dig=%b ft=%b expected seg=%h dp=%b dig=%b ft=%b",
                         k, seg, dp, dig, frame_tick, e_seg, e_dp, e_dig, e_ft);
            else pass_count++;
            check_count++;
            if ($countones(~dig) > 1) $display("[TB] FAIL random_onehot k=%0d: got dig=%b expected at most one low", k, dig);
            else pass_count++;
            if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) dp_mask = 6'($urandom);
            if ($urandom_range(0, 31) == 0) blink_mask = 6'($urandom);
            enable = ($urandom_range(0, 19) != 0);
        end
    endtask

    task automatic test_reset_mid_slot_and_blink();
        logic [6:0] want;
        int frame;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_count++;
        if ({seg, dp, dig, frame_tick} !== {7'h7F, 1'b1, 6'h3F, 1'b0})
            $display("[TB] FAIL async_reset: got seg=%h dp=%b dig=%b ft=%b expected seg=7f dp=1 dig=111111 ft=0",
                     seg, dp, dig, frame_tick);
        else pass_count++;
        for (int i = 0; i < 6; i++) d[i] = 4'(i + 1);
        dp_mask = '0;
        blink_mask = 6'b000001;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6 * FRAME; k++) begin
            @(negedge clk);
            check_count++;
            if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft})
                $display("[TB] FAIL blink k=%0d: got seg=%h dp=%b dig=%b ft=%b expected seg=%h dp=%b dig=%b ft=%b",
                         k, seg, dp, dig, frame_tick, e_seg, e_dp, e_dig, e_ft);
            else pass_count++;
            frame = (k - 1) / FRAME + 1;
            if (dig === 6'b111110) begin
                want = (frame == 1 || (BLINK_ON && (frame == 3 || frame == 4))) ? 7'h7F : 7'h79;
                check_count++;
                if (seg !== want) $display("[TB] FAIL blink_digit0 frame=%0d: got %h expected %h", frame, seg, want);
                else pass_count++;
            end
            if (dig === 6'b111101) begin
                want = (frame == 1) ? 7'h7F : 7'h24;
                check_count++;
                if (seg !== want) $display("[TB] FAIL steady_digit1 frame=%0d: got %h expected %h", frame, seg, want);
                else pass_count++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_digits_dp();
        test_frame_sync();
        test_codes();
        test_enable_off();
        test_random();
        test_reset_mid_slot_and_blink();
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
